// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator sequencer: opcodes, ALU selects, FSM states.
package cpu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_JC   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // ALU selects, shared with the datapath ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction decode; every control is quiet unless exec is high.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic       exec,
  output logic       mux_sel,
  output logic       load,
  output logic [1:0] alu_sel,
  output logic       is_jump,
  output logic       is_halt,
  output logic       upd_carry
);

  // Map opcode to datapath controls and sequencing hints during EXEC only
  always_comb begin
    mux_sel   = 1'b0;
    load      = 1'b0;
    alu_sel   = ALU_ADD;
    is_jump   = 1'b0;
    is_halt   = 1'b0;
    upd_carry = 1'b0;
    if (exec) begin
      case (opcode)
        OP_LDI:  load = 1'b1;
        OP_ADD:  begin mux_sel = 1'b1; load = 1'b1; alu_sel = ALU_ADD; upd_carry = 1'b1; end
        OP_SUB:  begin mux_sel = 1'b1; load = 1'b1; alu_sel = ALU_SUB; upd_carry = 1'b1; end
        OP_AND:  begin mux_sel = 1'b1; load = 1'b1; alu_sel = ALU_AND; end
        OP_OR:   begin mux_sel = 1'b1; load = 1'b1; alu_sel = ALU_OR;  end
        OP_JC:   is_jump = 1'b1;
        OP_HALT: is_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_control.sv
// Two-cycle-per-instruction sequencer (FETCH, EXEC) driving the accumulator datapath.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [7:0]        instr_data,
  input  logic              carry_in,
  output logic [DATA_W-1:0] imm_out,
  output logic              mux_sel,
  output logic              load,
  output logic [1:0]        alu_sel,
  output logic              busy,
  output logic              halted
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx;
  logic [7:0]        instr, instr_nx;
  logic              carry_flag, carry_nx;
  logic              is_jump, is_halt, upd_carry;

  cpu_decoder u_dec (
    .opcode    (instr[7:5]),
    .exec      (state == S_EXEC),
    .mux_sel   (mux_sel),
    .load      (load),
    .alu_sel   (alu_sel),
    .is_jump   (is_jump),
    .is_halt   (is_halt),
    .upd_carry (upd_carry)
  );

  assign instr_addr = pc;
  assign imm_out    = DATA_W'(instr[3:0]);
  assign busy       = (state == S_FETCH) || (state == S_EXEC);
  assign halted     = (state == S_HALT);

  // State, PC, instruction and carry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= '0;
      instr      <= '0;
      carry_flag <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      instr      <= instr_nx;
      carry_flag <= carry_nx;
    end
  end

  // Next-state: start only honoured when not busy; carry sampled at end of ADD/SUB
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    carry_nx = carry_flag;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_nx    = '0;
          carry_nx = 1'b0;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        instr_nx = instr_data;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (upd_carry) carry_nx = carry_in;
        if (is_halt) begin
          state_nx = S_HALT;
        end else begin
          state_nx = S_FETCH;
          if (is_jump && carry_flag) pc_nx = ADDR_W'(instr[3:0]);
          else                       pc_nx = pc + ADDR_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_control.sv
// Bench: sequencer + behavioural datapath + ROM, checked against an instruction-level model.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] instr_addr;
  logic [7:0] instr_data;
  logic       carry_in;
  logic [3:0] imm_out;
  logic       mux_sel, load, busy, halted;
  logic [1:0] alu_sel;

  logic [7:0] rom [16];
  logic [3:0] acc = 4'd0;
  logic [3:0] alu_res;

  int n_cmp = 0, n_bad = 0;
  int ld_total = 0, consec_total = 0, rst_ld_total = 0;
  logic prev_ld = 1'b0;

  always #5 clk = ~clk;

  cpu_control #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_addr(instr_addr),
    .instr_data(instr_data), .carry_in(carry_in), .imm_out(imm_out),
    .mux_sel(mux_sel), .load(load), .alu_sel(alu_sel), .busy(busy), .halted(halted)
  );

  assign instr_data = rom[instr_addr];

  // Datapath ALU: carry is the ADD carry-out, and for SUB it signals a borrow
  always_comb begin
    alu_res  = 4'd0;
    carry_in = 1'b0;
    case (alu_sel)
      2'b00: {carry_in, alu_res} = {1'b0, acc} + {1'b0, imm_out};
      2'b01: begin alu_res = acc - imm_out; carry_in = (acc < imm_out); end
      2'b10: alu_res = acc & imm_out;
      default: alu_res = acc | imm_out;
    endcase
  end

  // Datapath register (not tied to the sequencer reset)
  always @(posedge clk) if (load) acc <= mux_sel ? alu_res : imm_out;

  // Load-pulse monitor
  always @(negedge clk) begin
    if (load) ld_total <= ld_total + 1;
    if (load && prev_ld) consec_total <= consec_total + 1;
    if (load && !rst_n) rst_ld_total <= rst_ld_total + 1;
    prev_ld <= load;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_rom(input logic [7:0] w);
    for (int i = 0; i < 16; i++) rom[i] = w;
  endtask

  // Instruction-level reference: executes the ROM with plain integer arithmetic
  task automatic model(input int a0, output int a, output int pc, output int k,
                       output int loads);
    int c, op, im;
    bit done;
    a = a0; c = 0; pc = 0; k = 0; loads = 0; done = 0;
    while (!done && k < 200) begin
      op = rom[pc] >> 5;
      im = rom[pc] & 15;
      k++;
      case (op)
        0: pc = (pc + 1) % 16;
        1: begin a = im; loads++; pc = (pc + 1) % 16; end
        2: begin c = (a + im) > 15; a = (a + im) % 16; loads++; pc = (pc + 1) % 16; end
        3: begin c = (a < im); a = (a - im + 16) % 16; loads++; pc = (pc + 1) % 16; end
        4: begin a = a & im; loads++; pc = (pc + 1) % 16; end
        5: begin a = a | im; loads++; pc = (pc + 1) % 16; end
        6: pc = c ? im : (pc + 1) % 16;
        default: done = 1;
      endcase
    end
  endtask

  task automatic run_prog(input string tag);
    int ea, epc, ek, eld, cyc, ld0, cs0;
    model(int'(acc), ea, epc, ek, eld);
    ld0 = ld_total; cs0 = consec_total;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    while (!halted && cyc < 1000) begin
      @(negedge clk); cyc++;
    end
    check({tag, "_cycles"}, cyc, 1 + 2 * ek);
    check({tag, "_halted"}, halted, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_acc"}, acc, ea);
    check({tag, "_addr"}, instr_addr, epc);
    check({tag, "_loads"}, ld_total - ld0, eld);
    check({tag, "_consec"}, consec_total - cs0, 0);
  endtask

  initial begin
    int a_before, nb, wrapped, ld0;
    logic [3:0] prev_addr;
    fill_rom(8'hE0);
    #12;
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_load", load, 0);
    check("rst_addr", instr_addr, 0);
    check("rst_imm", imm_out, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Reset asserted while LDI 5 is in EXEC
    rom[0] = 8'h25;
    a_before = acc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("exec_load", load, 1);
    check("exec_imm", imm_out, 5);
    #1 rst_n = 1'b0;
    #1;
    check("arst_load", load, 0);
    check("arst_busy", busy, 0);
    check("arst_imm", imm_out, 0);
    check("arst_mux", mux_sel, 0);
    check("arst_alu", alu_sel, 0);
    @(negedge clk); @(negedge clk);
    check("arst_acc", acc, a_before);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", busy | halted, 0);
    check("arst_pc", instr_addr, 0);
    check("arst_noload", rst_ld_total, 0);

    // LDI 5, ADD 3, HALT
    fill_rom(8'hE0);
    rom[0] = 8'h25; rom[1] = 8'h43;
    run_prog("p1");
    check("p1_acc8", acc, 8);
    check("p1_pc2", instr_addr, 2);

    // LDI 4, SUB 1, JC 0, HALT: 4-1 has no borrow, so JC falls through
    fill_rom(8'hE0);
    rom[0] = 8'h24; rom[1] = 8'h61; rom[2] = 8'hC0;
    run_prog("p3");
    check("p3_acc3", acc, 3);

    // LDI 9, ADD 8, JC 5, LDI 1, HALT, OR 2, HALT
    fill_rom(8'hE0);
    rom[0] = 8'h29; rom[1] = 8'h48; rom[2] = 8'hC5; rom[3] = 8'h21;
    rom[5] = 8'hA2;
    run_prog("p2");
    check("p2_acc3", acc, 3);
    check("p2_pc6", instr_addr, 6);

    // Restart from HALT with carry left set: JC 2 must fall through
    fill_rom(8'hE0);
    rom[0] = 8'hC2; rom[1] = 8'h27;
    run_prog("rs");
    check("rs_acc7", acc, 7);

    // All-NOP program: wraps, ignores start while busy, never loads
    fill_rom(8'h00);
    ld0 = ld_total; nb = 0; wrapped = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    prev_addr = instr_addr;
    for (int i = 0; i < 50; i++) begin
      start = (i == 9 || i == 20);
      @(negedge clk);
      if (!busy) nb++;
      if (prev_addr == 4'd15 && instr_addr == 4'd0) wrapped = 1;
      prev_addr = instr_addr;
    end
    start = 1'b0;
    check("nop_busy", nb, 0);
    check("nop_wrap", wrapped, 1);
    check("nop_loads", ld_total - ld0, 0);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Random programs: forward-only jumps and a HALT at 15 keep them finite
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 15; i++) begin
        rom[i] = 8'($urandom);
        if (rom[i][7:5] == 3'b110)
          rom[i][3:0] = 4'($urandom_range(15, i + 1));
      end
      rom[15] = 8'hE0 | 8'($urandom_range(0, 31));
      run_prog($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
